// File: rtl/matrix_rxrec_ctrl.sv
// Record-level controller for the rx-to-host buffer: packs tag replies into fixed
// memory slots, prepends a header word per record and lets the host drain them in order.
module matrix_rxrec_ctrl #(
  parameter int NSLOT = 2,
  parameter int SLOTW = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        TagDataType,
  input  logic        rx_RecStart,
  input  logic        rx_ShiftLoad,
  input  logic [31:0] rx_ShiftDataOut,
  input  logic [7:0]  rx_ShiftBitCnt,
  input  logic        rx_RecEnd,
  input  logic        rx_RecAbort,
  input  logic        fifoRead,
  output logic [31:0] fifoDataOut,
  output logic        fifoDataValid,
  output logic        fifoRecDone,
  output logic        fifoEmpty,
  output logic        fifoFull,
  output logic [1:0]  fifoCnt,
  output logic        fifoOverflow,
  output logic        rx_RN16Received,
  output logic        rx_PCEPCReceived
);

  localparam int DEPTH = NSLOT * SLOTW;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(SLOTW + 1);

  typedef enum logic [1:0] {W_IDLE, W_COLL, W_HDR, W_DROP} wState_t;

  wState_t       wState;
  logic [1:0]    wSlot;
  logic [1:0]    rSlot;
  logic [IW-1:0] wIdx;
  logic [IW-1:0] rIdx;
  logic [10:0]   bitLen;
  logic          recType;
  logic [IW-1:0] slotLen [4];

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ramQ;
  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [31:0]   memWdata;
  logic [AW-1:0] rdAddr;

  logic          loadOk;
  logic          commit;
  logic          rdAccept;
  logic          rdLast;
  logic          freeSlot;
  logic [11:0]   bitSum;
  logic [10:0]   bitLenSat;
  logic [11:0]   wordsRaw;
  logic [IW-1:0] hdrLen;
  logic [31:0]   header;

  function automatic logic [AW-1:0] slotBase(input logic [1:0] s);
    return AW'(int'(s) * SLOTW);
  endfunction

  function automatic logic [1:0] nextSlot(input logic [1:0] s);
    return (int'(s) == NSLOT - 1) ? 2'd0 : s + 2'd1;
  endfunction

  assign fifoEmpty = (fifoCnt == 2'd0);
  assign fifoFull  = (fifoCnt == 2'(NSLOT));

  // Payload words past the slot capacity are dropped and no longer counted.
  assign loadOk    = (wState == W_COLL) && rx_ShiftLoad && (wIdx < IW'(SLOTW));
  assign commit    = (wState == W_HDR);
  assign bitSum    = {1'b0, bitLen} + {4'b0000, rx_ShiftBitCnt};
  assign bitLenSat = bitSum[11] ? 11'h7FF : bitSum[10:0];
  assign wordsRaw  = (({1'b0, bitLen} + 12'd31) >> 5) + 12'd1;
  assign hdrLen    = (wordsRaw > 12'(SLOTW)) ? IW'(SLOTW) : IW'(wordsRaw);
  assign header    = {recType, bitLen, 1'b1, {4'b0000, nextSlot(wSlot)}, 13'd0};

  assign rdAccept  = fifoRead && !fifoEmpty;
  assign rdAddr    = slotBase(rSlot) + AW'(rIdx);
  assign rdLast    = (rIdx == slotLen[rSlot] - IW'(1));
  assign freeSlot  = rdAccept && rdLast;

  always_comb begin
    memWe    = 1'b0;
    memWaddr = slotBase(wSlot) + AW'(wIdx);
    memWdata = rx_ShiftDataOut;
    if (commit) begin
      memWe    = 1'b1;
      memWaddr = slotBase(wSlot);
      memWdata = header;
    end else if (loadOk) begin
      memWe = 1'b1;
    end
  end

  // Read and write slots never coincide, so no bypass is needed.
  always_ff @(posedge Clk) begin
    if (memWe) mem[memWaddr] <= memWdata;
    if (rdAccept) ramQ <= rdAddr == rdAddr ? mem[rdAddr] : '0;
  end

  assign fifoDataOut = fifoDataValid ? ramQ : 32'd0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wState           <= W_IDLE;
      wSlot            <= 2'd0;
      wIdx             <= '0;
      bitLen           <= 11'd0;
      recType          <= 1'b0;
      fifoOverflow     <= 1'b0;
      rx_RN16Received  <= 1'b0;
      rx_PCEPCReceived <= 1'b0;
    end else begin
      rx_RN16Received  <= 1'b0;
      rx_PCEPCReceived <= 1'b0;
      case (wState)
        W_IDLE: begin
          if (rx_RecStart) begin
            if (fifoFull) begin
              wState <= W_DROP;
            end else begin
              wState  <= W_COLL;
              recType <= TagDataType;
              wIdx    <= IW'(1);
              bitLen  <= 11'd0;
            end
          end
        end
        W_COLL: begin
          if (loadOk) begin
            wIdx   <= wIdx + IW'(1);
            bitLen <= bitLenSat;
          end
          if (rx_RecAbort)    wState <= W_IDLE;
          else if (rx_RecEnd) wState <= W_HDR;
        end
        W_HDR: begin
          rx_RN16Received  <= !recType;
          rx_PCEPCReceived <= recType;
          wSlot            <= nextSlot(wSlot);
          wState           <= W_IDLE;
        end
        W_DROP: begin
          if (rx_RecAbort) begin
            wState <= W_IDLE;
          end else if (rx_RecEnd) begin
            fifoOverflow <= 1'b1;
            wState       <= W_IDLE;
          end
        end
        default: wState <= W_IDLE;
      endcase
    end
  end

  // Per-slot record length in words, captured at commit so the reader knows the last word.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) slotLen[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (commit && wSlot == 2'(i)) slotLen[i] <= hdrLen;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rSlot         <= 2'd0;
      rIdx          <= '0;
      fifoDataValid <= 1'b0;
      fifoRecDone   <= 1'b0;
    end else begin
      fifoDataValid <= rdAccept;
      fifoRecDone   <= freeSlot;
      if (rdAccept) begin
        if (rdLast) begin
          rIdx  <= '0;
          rSlot <= nextSlot(rSlot);
        end else begin
          rIdx <= rIdx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fifoCnt <= 2'd0;
    end else begin
      case ({commit, freeSlot})
        2'b10:   fifoCnt <= fifoCnt + 2'd1;
        2'b01:   fifoCnt <= fifoCnt - 2'd1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

endmodule
